// File: rtl/mixed_radix_counter_if.sv
// Handshake bundle for the mixed-radix counter.
// Sized by digit count and digit width.
interface mixed_radix_counter_if #(
  parameter int DIGITS = 2,
  parameter int W      = 4
);
  logic              en;
  logic              dir;
  logic              load;
  logic [DIGITS*W-1:0] load_val;
  logic [DIGITS*W-1:0] value;
  logic [DIGITS-1:0] digit_ov;
  logic              tc;
  logic              wrap;

  modport master (
    output en, dir, load, load_val,
    input  value, digit_ov, tc, wrap
  );

  modport slave (
    input  en, dir, load, load_val,
    output value, digit_ov, tc, wrap
  );
endinterface

// File: rtl/mixed_radix_counter.sv
// Cascade of modulo digits with up/down, load clamp,
// wrap or saturate at terminal, and carry look-ahead.
module mixed_radix_counter #(
  parameter int                  DIGITS   = 2,
  parameter int                  W        = 4,
  parameter logic [DIGITS*W-1:0] LIMITS   = {4'd5, 4'd9},
  parameter bit                  SATURATE = 1'b0
) (
  input logic                  clk,
  input logic                  rst,
  mixed_radix_counter_if.slave bus
);

  logic [DIGITS*W-1:0] value_q;
  logic [DIGITS*W-1:0] value_d;
  logic                wrap_q;
  logic                wrap_d;

  logic [DIGITS-1:0]   at_term;
  logic [DIGITS:0]     ci;
  logic                tc_all;
  logic                hold_sat;
  logic [DIGITS*W-1:0] step_val;
  logic [DIGITS*W-1:0] load_clamp;

  // terminal detect per digit for the current direction
  always_comb begin
    at_term = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.dir)
        at_term[i] = (value_q[i*W +: W] == '0);
      else
        at_term[i] = (value_q[i*W +: W] == LIMITS[i*W +: W]);
    end
  end

  assign tc_all   = &at_term;
  assign hold_sat = SATURATE && tc_all;

  // carry chain; the top bit marks a whole-counter roll
  always_comb begin
    ci    = '0;
    ci[0] = bus.en & ~hold_sat;
    for (int i = 0; i < DIGITS; i++)
      ci[i+1] = ci[i] & at_term[i];
  end

  // per-digit step: roll at terminal, else +/-1
  always_comb begin
    step_val = value_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (ci[i]) begin
        if (bus.dir) begin
          if (at_term[i])
            step_val[i*W +: W] = LIMITS[i*W +: W];
          else
            step_val[i*W +: W] = value_q[i*W +: W] - W'(1);
        end else begin
          if (at_term[i])
            step_val[i*W +: W] = '0;
          else
            step_val[i*W +: W] = value_q[i*W +: W] + W'(1);
        end
      end
    end
  end

  // clamp each loaded field to its digit limit
  always_comb begin
    load_clamp = bus.load_val;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.load_val[i*W +: W] > LIMITS[i*W +: W])
        load_clamp[i*W +: W] = LIMITS[i*W +: W];
    end
  end

  // next state: load beats step, step beats hold
  always_comb begin
    value_d = value_q;
    wrap_d  = 1'b0;
    if (bus.load) begin
      value_d = load_clamp;
    end else if (bus.en) begin
      value_d = step_val;
      wrap_d  = ci[DIGITS];
    end
  end

  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      value_q <= value_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.value    = value_q;
  assign bus.wrap     = wrap_q;
  assign bus.tc       = tc_all;
  assign bus.digit_ov = ci[DIGITS-1:0] & at_term;

endmodule

// File: tb/tb_mixed_radix_counter.sv
// Scoreboard bench for mixed_radix_counter across
// wrap, saturate, three-digit and one-bit configs.
module tb_mixed_radix_counter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mixed_radix_counter_if #(.DIGITS(2), .W(4)) b0 ();
  mixed_radix_counter_if #(.DIGITS(2), .W(4)) b1 ();
  mixed_radix_counter_if #(.DIGITS(3), .W(3)) b2 ();
  mixed_radix_counter_if #(.DIGITS(1), .W(1)) b3 ();

  mixed_radix_counter #(
    .DIGITS(2), .W(4), .LIMITS(8'h59), .SATURATE(1'b0)
  ) u0 (.clk(clk), .rst(rst), .bus(b0));

  mixed_radix_counter #(
    .DIGITS(2), .W(4), .LIMITS(8'h59), .SATURATE(1'b1)
  ) u1 (.clk(clk), .rst(rst), .bus(b1));

  mixed_radix_counter #(
    .DIGITS(3), .W(3), .LIMITS({3'd2, 3'd7, 3'd4}),
    .SATURATE(1'b0)
  ) u2 (.clk(clk), .rst(rst), .bus(b2));

  mixed_radix_counter #(
    .DIGITS(1), .W(1), .LIMITS(1'b1), .SATURATE(1'b0)
  ) u3 (.clk(clk), .rst(rst), .bus(b3));

  typedef struct {
    int          dut;
    logic [11:0] val;
    logic        wrap;
  } exp_t;

  exp_t sb[$];
  int   n_cnt[4];
  int   checks   = 0;
  int   failures = 0;

  function automatic int tot(int d);
    case (d)
      0, 1:    return 60;
      2:       return 120;
      default: return 2;
    endcase
  endfunction

  function automatic logic [11:0] enc(int d, int n);
    case (d)
      0, 1:    return {4'd0, 4'(n / 10), 4'(n % 10)};
      2:       return {3'd0, 3'(n / 40), 3'((n / 5) % 8), 3'(n % 5)};
      default: return 12'(n);
    endcase
  endfunction

  function automatic int clampn(int d, logic [11:0] lv);
    int a, b, c;
    case (d)
      0, 1: begin
        a = int'(lv[3:0]); if (a > 9) a = 9;
        b = int'(lv[7:4]); if (b > 5) b = 5;
        return b * 10 + a;
      end
      2: begin
        a = int'(lv[2:0]); if (a > 4) a = 4;
        b = int'(lv[5:3]);
        c = int'(lv[8:6]); if (c > 2) c = 2;
        return c * 40 + b * 5 + a;
      end
      default: return int'(lv[0]);
    endcase
  endfunction

  function automatic bit exp_tc(int d, bit dir);
    return dir ? (n_cnt[d] == 0) : (n_cnt[d] == tot(d) - 1);
  endfunction

  function automatic logic [1:0] exp_ov(int d, bit en, bit dir);
    bit t, lo;
    int n;
    n  = n_cnt[d];
    t  = exp_tc(d, dir);
    lo = dir ? (n % 10 == 0) : (n % 10 == 9);
    if (!en || (d == 1 && t)) return 2'b00;
    return {t, lo};
  endfunction

  function automatic logic [11:0] rd_val(int d);
    case (d)
      0:       return 12'(b0.value);
      1:       return 12'(b1.value);
      2:       return 12'(b2.value);
      default: return 12'(b3.value);
    endcase
  endfunction

  function automatic logic rd_wrap(int d);
    case (d)
      0:       return b0.wrap;
      1:       return b1.wrap;
      2:       return b2.wrap;
      default: return b3.wrap;
    endcase
  endfunction

  task automatic quiet();
    b0.en = 0; b0.load = 0;
    b1.en = 0; b1.load = 0;
    b2.en = 0; b2.load = 0;
    b3.en = 0; b3.load = 0;
  endtask

  task automatic drive(int d, bit en, bit dir, bit ld,
                       logic [11:0] lv);
    exp_t e;
    quiet();
    case (d)
      0: begin
        b0.en = en; b0.dir = dir; b0.load = ld; b0.load_val = lv[7:0];
      end
      1: begin
        b1.en = en; b1.dir = dir; b1.load = ld; b1.load_val = lv[7:0];
      end
      2: begin
        b2.en = en; b2.dir = dir; b2.load = ld; b2.load_val = lv[8:0];
      end
      default: begin
        b3.en = en; b3.dir = dir; b3.load = ld; b3.load_val = lv[0];
      end
    endcase
    e.dut  = d;
    e.wrap = 1'b0;
    if (ld) begin
      n_cnt[d] = clampn(d, lv);
    end else if (en) begin
      if (!dir) begin
        if (n_cnt[d] == tot(d) - 1) begin
          if (d != 1) begin n_cnt[d] = 0; e.wrap = 1'b1; end
        end else n_cnt[d]++;
      end else begin
        if (n_cnt[d] == 0) begin
          if (d != 1) begin n_cnt[d] = tot(d) - 1; e.wrap = 1'b1; end
        end else n_cnt[d]--;
      end
    end
    e.val = enc(d, n_cnt[d]);
    sb.push_back(e);
  endtask

  task automatic do_reset();
    quiet();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    foreach (n_cnt[i]) n_cnt[i] = 0;
    sb.delete();
  endtask

  task automatic test_reset();
    quiet();
    b0.dir = 0; b1.dir = 0; b2.dir = 0; b3.dir = 0;
    b0.load_val = 0; b1.load_val = 0;
    b2.load_val = 0; b3.load_val = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    foreach (n_cnt[i]) n_cnt[i] = 0;
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (rd_val(d) !== 12'h000 || rd_wrap(d) !== 1'b0) begin
        failures++;
        $display("FAIL reset dut%0d got=%h/%b exp=000/0",
                 d, rd_val(d), rd_wrap(d));
      end
    end
  endtask

  task automatic test_count_up();
    exp_t e;
    logic [1:0] eo;
    bit et;
    int wraps = 0;
    for (int k = 0; k < 60; k++) begin
      eo = exp_ov(0, 1'b1, 1'b0);
      et = exp_tc(0, 1'b0);
      drive(0, 1'b1, 1'b0, 1'b0, 12'h0);
      #1;
      checks++;
      if (b0.digit_ov !== eo || b0.tc !== et) begin
        failures++;
        $display("FAIL up_ov step%0d got=%b/%b exp=%b/%b",
                 k, b0.digit_ov, b0.tc, eo, et);
      end
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (rd_val(e.dut) !== e.val || rd_wrap(e.dut) !== e.wrap) begin
        failures++;
        $display("FAIL up_val step%0d got=%h/%b exp=%h/%b",
                 k, rd_val(e.dut), rd_wrap(e.dut), e.val, e.wrap);
      end
      if (b0.wrap) wraps++;
    end
    checks++;
    if (wraps != 1) begin
      failures++;
      $display("FAIL up_wraps got=%0d exp=1", wraps);
    end
  endtask

  task automatic test_count_down();
    exp_t e;
    bit et;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      et = exp_tc(0, 1'b1);
      drive(0, 1'b1, 1'b1, 1'b0, 12'h0);
      #1;
      checks++;
      if (b0.tc !== et) begin
        failures++;
        $display("FAIL down_tc step%0d got=%b exp=%b", k, b0.tc, et);
      end
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (rd_val(e.dut) !== e.val || rd_wrap(e.dut) !== e.wrap) begin
        failures++;
        $display("FAIL down_val step%0d got=%h/%b exp=%h/%b",
                 k, rd_val(e.dut), rd_wrap(e.dut), e.val, e.wrap);
      end
    end
  endtask

  task automatic test_load_clamp();
    exp_t e;
    logic [11:0] lv[4] = '{12'h07F, 12'h000, 12'h000, 12'h039};
    bit          ld[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    bit          en[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 4; k++) begin
      drive(0, en[k], 1'b0, ld[k], lv[k]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (rd_val(e.dut) !== e.val || rd_wrap(e.dut) !== e.wrap) begin
        failures++;
        $display("FAIL load step%0d got=%h/%b exp=%h/%b",
                 k, rd_val(e.dut), rd_wrap(e.dut), e.val, e.wrap);
      end
    end
  endtask

  task automatic test_saturate();
    exp_t e;
    logic [1:0] eo;
    bit ld[7] = '{1, 0, 0, 0, 0, 1, 0};
    bit dr[7] = '{0, 0, 0, 0, 1, 1, 1};
    logic [11:0] lv[7] = '{12'h58, 0, 0, 0, 0, 12'h01, 0};
    for (int k = 0; k < 9; k++) begin
      int j;
      j  = (k < 7) ? k : 6;
      eo = exp_ov(1, !ld[j], dr[j]);
      drive(1, !ld[j], dr[j], ld[j], lv[j]);
      #1;
      checks++;
      if (b1.digit_ov !== eo) begin
        failures++;
        $display("FAIL sat_ov step%0d got=%b exp=%b",
                 k, b1.digit_ov, eo);
      end
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (rd_val(e.dut) !== e.val || rd_wrap(e.dut) !== e.wrap) begin
        failures++;
        $display("FAIL sat_val step%0d got=%h/%b exp=%h/%b",
                 k, rd_val(e.dut), rd_wrap(e.dut), e.val, e.wrap);
      end
    end
  endtask

  task automatic test_alt_dir();
    exp_t e;
    drive(0, 1'b0, 1'b0, 1'b1, 12'h09);
    @(posedge clk); #1;
    void'(sb.pop_front());
    for (int k = 0; k < 8; k++) begin
      bit en;
      en = (k < 3);
      drive(0, en, k[0], 1'b0, 12'h0);
      #1;
      checks++;
      if (!en && b0.digit_ov !== 2'b00) begin
        failures++;
        $display("FAIL idle_ov step%0d got=%b exp=00",
                 k, b0.digit_ov);
      end
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (rd_val(e.dut) !== e.val || rd_wrap(e.dut) !== e.wrap) begin
        failures++;
        $display("FAIL alt_val step%0d got=%h/%b exp=%h/%b",
                 k, rd_val(e.dut), rd_wrap(e.dut), e.val, e.wrap);
      end
    end
  endtask

  task automatic test_rst_override();
    exp_t e;
    do_reset();
    for (int k = 0; k < 37; k++) begin
      drive(0, 1'b1, 1'b0, 1'b0, 12'h0);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (rd_val(e.dut) !== e.val) begin
        failures++;
        $display("FAIL pre_rst step%0d got=%h exp=%h",
                 k, rd_val(e.dut), e.val);
      end
    end
    drive(0, 1'b1, 1'b0, 1'b1, 12'h55);
    void'(sb.pop_back());
    rst = 1'b1;
    foreach (n_cnt[i]) n_cnt[i] = 0;
    sb.push_back('{0, 12'h000, 1'b0});
    @(posedge clk); #1;
    rst = 1'b0;
    e = sb.pop_front();
    checks++;
    if (rd_val(e.dut) !== e.val || rd_wrap(e.dut) !== e.wrap) begin
      failures++;
      $display("FAIL rst_override got=%h/%b exp=%h/%b",
               rd_val(e.dut), rd_wrap(e.dut), e.val, e.wrap);
    end
  endtask

  task automatic test_three_digit();
    exp_t e;
    int wraps = 0;
    for (int k = 0; k < 120; k++) begin
      drive(2, 1'b1, 1'b0, 1'b0, 12'h0);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (rd_val(e.dut) !== e.val || rd_wrap(e.dut) !== e.wrap) begin
        failures++;
        $display("FAIL three step%0d got=%h/%b exp=%h/%b",
                 k, rd_val(e.dut), rd_wrap(e.dut), e.val, e.wrap);
      end
      if (b2.wrap) wraps++;
    end
    checks++;
    if (wraps != 1 || b2.value !== 9'd0) begin
      failures++;
      $display("FAIL three_end got=%0d/%h exp=1/000",
               wraps, b2.value);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int k = 0; k < 6; k++) begin
      drive(3, 1'b1, ~k[0], 1'b0, 12'h0);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (rd_val(e.dut) !== e.val || rd_wrap(e.dut) !== e.wrap) begin
        failures++;
        $display("FAIL b2b step%0d got=%h/%b exp=%h/%b",
                 k, rd_val(e.dut), rd_wrap(e.dut), e.val, e.wrap);
      end
    end
    drive(3, 1'b0, 1'b0, 1'b0, 12'h0);
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if (rd_wrap(e.dut) !== e.wrap) begin
      failures++;
      $display("FAIL b2b_drop got=%b exp=%b", rd_wrap(e.dut), e.wrap);
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_count_up();
    test_count_down();
    test_load_clamp();
    test_saturate();
    test_alt_dir();
    test_rst_override();
    test_three_digit();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
